// File: rtl/acc_sequencer.sv
// Accumulator sequencer: five-state FSM driving a 16-bit ALU
// with a bit-serial shift-add multiplier.
module acc_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [3:0]  OPC,
  input  logic [15:0] DIN,
  input  logic        LD1,
  input  logic        LD2,
  output logic [15:0] AC,
  output logic        C,
  output logic [15:0] T,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, MUL, WB
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  ir;
  logic [4:0]  sc;
  logic [15:0] r1, r2;
  logic [31:0] prod, mcand;
  logic [15:0] mplier;
  logic [15:0] res;
  logic        res_c;
  logic        res_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // MUL runs for SC=1..16, then write-back
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (START) state_nx = DECODE;
      DECODE:  state_nx = (ir == 4'h9) ? MUL : EXEC;
      EXEC:    state_nx = WB;
      MUL:     if (sc == 5'd16) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != IDLE);
    T    = '0;
    if (state != IDLE && !sc[4]) T[sc[3:0]] = 1'b1;
  end

  always_comb begin
    res     = AC;
    res_c   = C;
    res_err = 1'b0;
    unique case (ir)
      4'h0: ;
      4'h1: {res_c, res} = {1'b0, r1} + {1'b0, r2};
      4'h2: {res_c, res} = {1'b0, r1} - {1'b0, r2};
      4'h3: begin res = r1 & r2; res_c = 1'b0; end
      4'h4: begin res = r1 | r2; res_c = 1'b0; end
      4'h5: begin res = r1 ^ r2; res_c = 1'b0; end
      4'h6: begin res = ~r1;     res_c = 1'b0; end
      4'h7: begin res = {r1[14:0], 1'b0}; res_c = r1[15]; end
      4'h8: begin res = {1'b0, r1[15:1]}; res_c = r1[0];  end
      4'h9: begin res = prod[15:0]; res_c = |prod[31:16]; end
      4'hA: {res_c, res} = {1'b0, AC} + 17'd1;
      4'hB: {res_c, res} = {1'b0, AC} - 17'd1;
      4'hC: begin res = r1;    res_c = 1'b0; end
      4'hD: begin res = '0;    res_c = 1'b0; end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      AC     <= '0;
      C      <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      ir     <= '0;
      sc     <= '0;
      r1     <= '0;
      r2     <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      unique case (state)
        IDLE: begin
          sc <= '0;
          if (START) begin
            ir <= OPC;
          end else begin
            if (LD1) r1 <= DIN;
            if (LD2) r2 <= DIN;
          end
        end
        DECODE: begin
          sc     <= sc + 5'd1;
          prod   <= '0;
          mcand  <= {16'h0000, r1};
          mplier <= r2;
        end
        EXEC: sc <= sc + 5'd1;
        MUL: begin
          sc     <= sc + 5'd1;
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= {mcand[30:0], 1'b0};
          mplier <= {1'b0, mplier[15:1]};
        end
        WB: begin
          sc   <= '0;
          AC   <= res;
          C    <= res_c;
          DONE <= 1'b1;
          ERR  <= res_err;
        end
        default: sc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: opcode table plus
// handshake, busy-lockout, retrigger and reset corner cases.
module tb_acc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N, START, LD1, LD2;
  logic [3:0]  OPC;
  logic [15:0] DIN;
  logic [15:0] AC, T;
  logic        C, BUSY, DONE, ERR;

  int errors = 0;
  int checks = 0;

  acc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OPC(OPC),
    .DIN(DIN), .LD1(LD1), .LD2(LD2), .AC(AC), .C(C),
    .T(T), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [3:0]  opc;
    logic [15:0] ac;
    logic        c;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    LD1 = 1'b1; DIN = a;
    @(negedge CLK);
    LD1 = 1'b0; LD2 = 1'b1; DIN = b;
    @(negedge CLK);
    LD2 = 1'b0;
  endtask

  // lat = edges after the accepting edge until DONE is seen;
  // inj >= 0 pulses START/LD1 (DIN=1234) at that lat while busy
  task automatic run_op(input logic [3:0] opc, input int inj,
                        output int lat);
    logic [15:0] texp;
    @(negedge CLK);
    START = 1'b1; OPC = opc;
    @(negedge CLK);
    START = 1'b0;
    lat = 0;
    while (!DONE && lat < 40) begin
      texp = (lat < 16) ? (16'h0001 << lat) : 16'h0000;
      chk($sformatf("busy op%h lat%0d", opc, lat), BUSY, 1);
      chk($sformatf("T op%h lat%0d", opc, lat), T, texp);
      START = (lat == inj);
      LD1   = (lat == inj);
      if (lat == inj) begin OPC = 4'hC; DIN = 16'h1234; end
      @(negedge CLK);
      lat++;
    end
    START = 1'b0; LD1 = 1'b0;
    if (!DONE) chk("done timeout", 0, 1);
    chk($sformatf("idle busy op%h", opc), BUSY, 0);
    chk($sformatf("idle T op%h", opc), T, 0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b1, 16'h00FF, 16'h0F01, 4'h1, 16'h1000, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b1, 16'hFFFF, 16'h0002, 4'h1, 16'h0001, 1'b1, 1'b0, 3};
    vecs[2]  = '{1'b1, 16'h0003, 16'h0005, 4'h2, 16'hFFFE, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 4'hA, 16'hFFFF, 1'b0, 1'b0, 3};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 4'hA, 16'h0000, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 4'hB, 16'hFFFF, 1'b1, 1'b0, 3};
    vecs[6]  = '{1'b1, 16'h0100, 16'h0100, 4'h9, 16'h0000, 1'b1, 1'b0, 18};
    vecs[7]  = '{1'b1, 16'h00FF, 16'h0101, 4'h9, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[8]  = '{1'b1, 16'hA5A5, 16'h0FF0, 4'h3, 16'h05A0, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 4'h4, 16'hAFF5, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 4'h5, 16'hAA55, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 4'h6, 16'h5A5A, 1'b0, 1'b0, 3};
    vecs[12] = '{1'b0, 16'h0000, 16'h0000, 4'hC, 16'hA5A5, 1'b0, 1'b0, 3};
    vecs[13] = '{1'b0, 16'h0000, 16'h0000, 4'h7, 16'h4B4A, 1'b1, 1'b0, 3};
    vecs[14] = '{1'b0, 16'h0000, 16'h0000, 4'h0, 16'h4B4A, 1'b1, 1'b0, 3};
    vecs[15] = '{1'b0, 16'h0000, 16'h0000, 4'h8, 16'h52D2, 1'b1, 1'b0, 3};
    vecs[16] = '{1'b0, 16'h0000, 16'h0000, 4'hE, 16'h52D2, 1'b1, 1'b1, 3};
    vecs[17] = '{1'b0, 16'h0000, 16'h0000, 4'hD, 16'h0000, 1'b0, 1'b0, 3};
    vecs[18] = '{1'b0, 16'h0000, 16'h0000, 4'hF, 16'h0000, 1'b0, 1'b1, 3};
    vecs[19] = '{1'b0, 16'h0000, 16'h0000, 4'h2, 16'h95B5, 1'b0, 1'b0, 3};
    vecs[20] = '{1'b1, 16'h0012, 16'h1234, 4'h9, 16'h47A8, 1'b1, 1'b0, 18};

    RST_N = 1'b0; START = 1'b0; LD1 = 1'b0; LD2 = 1'b0;
    OPC = 4'h0; DIN = 16'h0000;
    repeat (2) @(negedge CLK);
    chk("rst AC", AC, 0);
    chk("rst C", C, 0);
    chk("rst T", T, 0);
    chk("rst BUSY", BUSY, 0);
    chk("rst DONE", DONE, 0);
    chk("rst ERR", ERR, 0);
    RST_N = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].ld) load(vecs[i].r1, vecs[i].r2);
      run_op(vecs[i].opc, -1, lat);
      chk($sformatf("v%0d lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d AC", i), AC, vecs[i].ac);
      chk($sformatf("v%0d C", i), C, vecs[i].c);
      chk($sformatf("v%0d ERR", i), ERR, vecs[i].err);
      @(negedge CLK);
      chk($sformatf("v%0d DONE pulse", i), DONE, 0);
      chk($sformatf("v%0d ERR pulse", i), ERR, 0);
    end

    // illegal op with START/LD1 poked while busy
    run_op(4'hE, 1, lat);
    chk("busy-ign lat", lat, 3);
    chk("busy-ign ERR", ERR, 1);
    chk("busy-ign AC", AC, 16'h47A8);
    @(negedge CLK);
    chk("busy-ign no retrig", BUSY, 0);
    run_op(4'hC, -1, lat);
    chk("busy-ign R1", AC, 16'h0012);

    // START beats LD1, then held START retriggers with DONE
    @(negedge CLK);
    START = 1'b1; OPC = 4'hC; LD1 = 1'b1; DIN = 16'hABCD;
    @(negedge CLK);
    LD1 = 1'b0;
    lat = 0;
    while (!DONE && lat < 40) begin @(negedge CLK); lat++; end
    chk("prio lat", lat, 3);
    chk("prio AC", AC, 16'h0012);
    OPC = 4'hA;
    @(negedge CLK);
    chk("retrig BUSY", BUSY, 1);
    chk("retrig DONE", DONE, 0);
    chk("retrig T", T, 16'h0001);
    START = 1'b0;
    lat = 0;
    while (!DONE && lat < 40) begin @(negedge CLK); lat++; end
    chk("retrig lat", lat, 3);
    chk("retrig AC", AC, 16'h0013);
    chk("retrig C", C, 0);

    // reset in the middle of MUL at SC=8
    load(16'h5555, 16'h0000);
    run_op(4'hC, -1, lat);
    chk("pre-rst AC", AC, 16'h5555);
    load(16'h0100, 16'h0100);
    @(negedge CLK);
    START = 1'b1; OPC = 4'h9;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    chk("mul sc8 T", T, 16'h0100);
    chk("mul sc8 AC", AC, 16'h5555);
    RST_N = 1'b0; START = 1'b1; LD1 = 1'b1; DIN = 16'hBEEF;
    @(negedge CLK);
    chk("mrst AC", AC, 0);
    chk("mrst C", C, 0);
    chk("mrst BUSY", BUSY, 0);
    chk("mrst T", T, 0);
    chk("mrst DONE", DONE, 0);
    RST_N = 1'b1; START = 1'b0; LD1 = 1'b0;
    lat = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE) lat++;
    end
    chk("mrst no DONE", lat, 0);
    run_op(4'hC, -1, lat);
    chk("mrst R1 cleared", AC, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
